// File: rtl/npc_duty_scheduler.sv
// Duty-command scheduler for one NPC PWM channel: soft start/stop in fixed steps
// once per carrier period, clamped target, immediate latched fault shutdown.
module npc_duty_scheduler #(
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned STEP     = 10,
  parameter int unsigned DUTY_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fault,
  input  logic [9:0] target,
  output logic [9:0] duty,
  output logic       period_tick,
  output logic       running,
  output logic       at_target,
  output logic       fault_latched
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD - 1);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] DMAX_W = 11'(DUTY_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    RUN,
    RAMP_DOWN,
    FAULT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic          tick;
  logic [9:0]    duty_r;
  logic [10:0]   duty_w;
  logic [10:0]   duty_next;
  logic [10:0]   tgt_c;
  logic [10:0]   toward;
  logic [10:0]   down;

  assign tick      = (pcnt == PCNT_LAST);
  assign pcnt_next = tick ? '0 : pcnt + 1'b1;
  assign duty_w    = {1'b0, duty_r};
  assign tgt_c     = ({1'b0, target} > DMAX_W) ? DMAX_W : {1'b0, target};
  assign duty      = duty_r;

  // One step toward the clamped target, landing exactly on it when within STEP.
  always_comb begin
    if (tgt_c >= duty_w) begin
      toward = ((tgt_c - duty_w) <= STEP_W) ? tgt_c : duty_w + STEP_W;
    end else begin
      toward = ((duty_w - tgt_c) <= STEP_W) ? tgt_c : duty_w - STEP_W;
    end
    down = (duty_w > STEP_W) ? duty_w - STEP_W : 11'd0;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    duty_next  = duty_w;
    if (fault) begin
      state_next = FAULT;
      duty_next  = 11'd0;
    end else begin
      unique case (state)
        FAULT: begin
          duty_next = 11'd0;
          if (!enable) state_next = IDLE;
        end
        IDLE: begin
          if (tick && enable) begin
            duty_next  = toward;
            state_next = (toward == tgt_c) ? RUN : RAMP;
          end
        end
        RAMP, RUN: begin
          if (tick) begin
            if (!enable) begin
              duty_next  = down;
              state_next = RAMP_DOWN;
            end else begin
              duty_next  = toward;
              state_next = (toward == tgt_c) ? RUN : RAMP;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (enable) begin
              duty_next  = toward;
              state_next = (toward == tgt_c) ? RUN : RAMP;
            end else begin
              duty_next  = down;
              state_next = (down == 11'd0) ? IDLE : RAMP_DOWN;
            end
          end
        end
        default: begin
          state_next = IDLE;
          duty_next  = 11'd0;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they move with duty.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pcnt          <= '0;
      duty_r        <= '0;
      period_tick   <= 1'b0;
      running       <= 1'b0;
      at_target     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_next;
      pcnt          <= pcnt_next;
      duty_r        <= duty_next[9:0];
      period_tick   <= (pcnt_next == PCNT_LAST);
      running       <= (state_next == RAMP) || (state_next == RUN) || (state_next == RAMP_DOWN);
      at_target     <= (state_next == RUN);
      fault_latched <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_npc_duty_scheduler.sv
// Self-checking bench for npc_duty_scheduler: directed scenarios with fixed expected
// duty sequences plus randomized traffic against a per-cycle behavioural model.
module tb_npc_duty_scheduler;

  localparam int P  = 20;
  localparam int S  = 10;
  localparam int DM = 1000;

  localparam int S_IDLE  = 0;
  localparam int S_RAMP  = 1;
  localparam int S_RUN   = 2;
  localparam int S_DOWN  = 3;
  localparam int S_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fault = 1'b0;
  logic [9:0] target = 10'd0;
  logic [9:0] duty;
  logic       period_tick;
  logic       running;
  logic       at_target;
  logic       fault_latched;
  logic [13:0] dut_outs;

  int n_vec = 0;
  int n_bad = 0;

  int m_pcnt = 0;
  int m_duty = 0;
  int m_st   = S_IDLE;

  npc_duty_scheduler #(.PERIOD(P), .STEP(S), .DUTY_MAX(DM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .target(target),
    .duty(duty), .period_tick(period_tick), .running(running),
    .at_target(at_target), .fault_latched(fault_latched)
  );

  assign dut_outs = {duty, period_tick, running, at_target, fault_latched};

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic int approach(int cur, int goal);
    int gap = goal - cur;
    if (gap <= S && gap >= -S) return goal;
    return (gap > 0) ? cur + S : cur - S;
  endfunction

  // Model of one clock edge, applied from the inputs the DUT just sampled.
  task automatic model_edge();
    bit was_tick;
    int tc;
    if (!rst_n) begin
      m_pcnt = 0;
      m_duty = 0;
      m_st   = S_IDLE;
      return;
    end
    was_tick = (m_pcnt == P - 1);
    m_pcnt   = (m_pcnt + 1) % P;
    tc       = (int'(target) > DM) ? DM : int'(target);
    if (fault) begin
      m_duty = 0;
      m_st   = S_FAULT;
    end else if (m_st == S_FAULT) begin
      if (!enable) m_st = S_IDLE;
    end else if (was_tick) begin
      if (enable && (m_st != S_IDLE || tc >= 0)) begin
        m_duty = approach(m_duty, tc);
        m_st   = (m_duty == tc) ? S_RUN : S_RAMP;
      end else if (m_st == S_RAMP || m_st == S_RUN || m_st == S_DOWN) begin
        m_duty = (m_duty > S) ? m_duty - S : 0;
        m_st   = (m_st == S_DOWN && m_duty == 0) ? S_IDLE : S_DOWN;
      end
    end
  endtask

  function automatic logic [13:0] expected();
    logic [9:0] d = 10'(m_duty);
    return {d, 1'(m_pcnt == P - 1), 1'(m_st == S_RAMP || m_st == S_RUN || m_st == S_DOWN),
            1'(m_st == S_RUN), 1'(m_st == S_FAULT)};
  endfunction

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fault = 1'b0; target = 10'd0;
    repeat (3) advance();
    n_vec++;
    if (dut_outs !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want %h", dut_outs, 14'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k < P; k++) begin
      advance();
      n_vec++;
      if (period_tick !== (k == P - 1)) begin
        n_bad++;
        $display("FAIL first_tick cycle %0d: got %b want %b", k, period_tick, (k == P - 1));
      end
      n_vec++;
      if (dut_outs !== expected()) begin
        n_bad++;
        $display("FAIL reset_model cycle %0d: got %h want %h", k, dut_outs, expected());
      end
    end
  endtask

  task automatic test_soft_start();
    int exp_seq[10] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 95};
    enable = 1'b1; target = 10'd95;
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < P; c++) begin
        advance();
        n_vec++;
        if (dut_outs !== expected()) begin
          n_bad++;
          $display("FAIL soft_start_model: got %h want %h", dut_outs, expected());
        end
        if (m_pcnt == 0) break;
      end
      n_vec++;
      if (duty !== 10'(exp_seq[t]) || at_target !== (t == 9)) begin
        n_bad++;
        $display("FAIL soft_start tick %0d: got duty %0d at_target %b want %0d %b",
                 t + 1, duty, at_target, exp_seq[t], (t == 9));
      end
    end
  endtask

  task automatic test_retarget();
    int exp_seq[5] = '{85, 75, 65, 60, 63};
    target = 10'd60;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) target = 10'd63;
      for (int c = 0; c < P; c++) begin
        advance();
        n_vec++;
        if (dut_outs !== expected()) begin
          n_bad++;
          $display("FAIL retarget_model: got %h want %h", dut_outs, expected());
        end
        if (m_pcnt == 0) break;
      end
      n_vec++;
      if (duty !== 10'(exp_seq[t]) || at_target !== (t >= 3)) begin
        n_bad++;
        $display("FAIL retarget tick %0d: got duty %0d at_target %b want %0d %b",
                 t + 1, duty, at_target, exp_seq[t], (t >= 3));
      end
    end
  endtask

  task automatic test_clamp();
    target = 10'd0;
    for (int t = 0; t < 7; t++) begin
      for (int c = 0; c < P; c++) begin
        advance();
        n_vec++;
        if (dut_outs !== expected()) begin
          n_bad++;
          $display("FAIL clamp_down_model: got %h want %h", dut_outs, expected());
        end
        if (m_pcnt == 0) break;
      end
    end
    n_vec++;
    if (duty !== 10'd0 || at_target !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_target: got duty %0d at_target %b want 0 1", duty, at_target);
    end
    target = 10'd1023;
    for (int t = 0; t < 101; t++) begin
      for (int c = 0; c < P; c++) begin
        advance();
        n_vec++;
        if (dut_outs !== expected() || duty > 10'd1000) begin
          n_bad++;
          $display("FAIL clamp_model: got %h want %h", dut_outs, expected());
        end
        if (m_pcnt == 0) break;
      end
      n_vec++;
      if (duty !== 10'((t < 100) ? 10 * (t + 1) : 1000) || at_target !== (t >= 99)) begin
        n_bad++;
        $display("FAIL clamp tick %0d: got duty %0d at_target %b want %0d %b", t + 1, duty,
                 at_target, (t < 100) ? 10 * (t + 1) : 1000, (t >= 99));
      end
    end
  endtask

  task automatic test_soft_stop();
    int exp_down[10] = '{85, 75, 65, 55, 45, 35, 25, 15, 5, 0};
    int exp_up[5]    = '{55, 65, 75, 85, 95};
    target = 10'd95;
    for (int t = 0; t < 91; t++) begin
      for (int c = 0; c < P; c++) begin
        advance();
        n_vec++;
        if (dut_outs !== expected()) begin
          n_bad++;
          $display("FAIL descend_model: got %h want %h", dut_outs, expected());
        end
        if (m_pcnt == 0) break;
      end
    end
    n_vec++;
    if (duty !== 10'd95 || at_target !== 1'b1) begin
      n_bad++;
      $display("FAIL descend_end: got duty %0d at_target %b want 95 1", duty, at_target);
    end
    for (int pass = 0; pass < 2; pass++) begin
      enable = 1'b0;
      for (int t = 0; t < ((pass == 0) ? 10 : 5); t++) begin
        for (int c = 0; c < P; c++) begin
          advance();
          n_vec++;
          if (dut_outs !== expected()) begin
            n_bad++;
            $display("FAIL soft_stop_model: got %h want %h", dut_outs, expected());
          end
          if (m_pcnt == 0) break;
        end
        n_vec++;
        if (duty !== 10'(exp_down[t]) || running !== (t < 9)) begin
          n_bad++;
          $display("FAIL soft_stop tick %0d: got duty %0d running %b want %0d %b",
                   t + 1, duty, running, exp_down[t], (t < 9));
        end
      end
      enable = 1'b1;
      for (int t = 0; t < ((pass == 0) ? 10 : 5); t++) begin
        for (int c = 0; c < P; c++) begin
          advance();
          n_vec++;
          if (dut_outs !== expected()) begin
            n_bad++;
            $display("FAIL reenable_model: got %h want %h", dut_outs, expected());
          end
          if (m_pcnt == 0) break;
        end
        if (pass == 1) begin
          n_vec++;
          if (duty !== 10'(exp_up[t]) || at_target !== (t == 4)) begin
            n_bad++;
            $display("FAIL reenable tick %0d: got duty %0d at_target %b want %0d %b",
                     t + 1, duty, at_target, exp_up[t], (t == 4));
          end
        end
      end
      n_vec++;
      if (duty !== 10'd95 || at_target !== 1'b1) begin
        n_bad++;
        $display("FAIL restart_end pass %0d: got duty %0d want 95", pass, duty);
      end
    end
  endtask

  task automatic test_fault();
    for (int c = 0; c < P && m_pcnt != P / 2; c++) advance();
    fault = 1'b1;
    advance();
    fault = 1'b0;
    n_vec++;
    if (duty !== 10'd0 || fault_latched !== 1'b1 || running !== 1'b0 || m_pcnt != P / 2 + 1) begin
      n_bad++;
      $display("FAIL fault_latency: got duty %0d fault_latched %b want 0 1", duty, fault_latched);
    end
    for (int c = 0; c < 2 * P; c++) begin
      advance();
      n_vec++;
      if (dut_outs !== expected() || fault_latched !== 1'b1) begin
        n_bad++;
        $display("FAIL fault_hold: got %h want %h", dut_outs, expected());
      end
    end
    enable = 1'b0;
    advance();
    n_vec++;
    if (fault_latched !== 1'b0 || running !== 1'b0 || duty !== 10'd0) begin
      n_bad++;
      $display("FAIL fault_exit: got fault_latched %b running %b want 0 0", fault_latched, running);
    end
    enable = 1'b1;
    for (int c = 0; c < P; c++) begin
      advance();
      n_vec++;
      if (dut_outs !== expected()) begin
        n_bad++;
        $display("FAIL fault_restart_model: got %h want %h", dut_outs, expected());
      end
      if (m_pcnt == 0) break;
    end
    n_vec++;
    if (duty !== 10'd10 || running !== 1'b1 || at_target !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_restart: got duty %0d running %b want 10 1", duty, running);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) target = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      fault = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      advance();
      n_vec++;
      if (dut_outs !== expected()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h want %h", c, dut_outs, expected());
      end
    end
    fault = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    enable = 1'b0;
    advance();
    enable = 1'b1;
    target = 10'd500;
    for (int c = 0; c < 120 * P; c++) begin
      advance();
      n_vec++;
      if (dut_outs !== expected()) begin
        n_bad++;
        $display("FAIL reset_mid_model: got %h want %h", dut_outs, expected());
      end
      if (m_duty == 500 && m_pcnt == P / 2) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!reached || duty !== 10'd500) begin
      n_bad++;
      $display("FAIL reset_mid_reach: got duty %0d want 500", duty);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      advance();
      n_vec++;
      if (dut_outs !== 14'd0) begin
        n_bad++;
        $display("FAIL reset_mid cycle %0d: got %h want %h", c, dut_outs, 14'd0);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k < P; k++) begin
      advance();
      n_vec++;
      if (period_tick !== (k == P - 1) || duty !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_mid_tick cycle %0d: got tick %b duty %0d want %b 0",
                 k, period_tick, duty, (k == P - 1));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_soft_start();
    test_retarget();
    test_clamp();
    test_soft_stop();
    test_fault();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
